// File: rtl/iob_eth_rx_ctrl.sv
// iob_eth_rx_ctrl: receive-side frame controller for the Ethernet MAC.
// Tracks frames arriving from the RX datapath. It steers their bytes into one
// of two buffer slots used as a ping-pong queue, and commits frames that are
// good and within the length limits. Committed frames are handed to the host
// in arrival order.
//
// Ports
//   RX_CLK       receive clock, rising edge
//   rx_rst       asynchronous active-high reset
//   dp_sof       start-of-frame pulse from the datapath
//   dp_wr        one byte valid this cycle
//   dp_eof       end-of-frame pulse
//   dp_crc_ok    FCS result, meaningful only with dp_eof
//   buf_slot     slot being written
//   buf_addr     byte address within that slot
//   buf_we       buffer write enable (combinational from dp_wr)
//   frame_ready  a committed frame awaits the host
//   frame_slot   slot holding the oldest committed frame
//   frame_len    byte length of that frame
//   frame_ack    host has consumed the frame in frame_slot
//   drop_cnt     saturating count of frames dropped for lack of a free slot
//   err_cnt      saturating count of frames discarded (CRC, length, abort)
module iob_eth_rx_ctrl #(
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned MIN_LEN = 64
) (
  input  logic        RX_CLK,
  input  logic        rx_rst,
  input  logic        dp_sof,
  input  logic        dp_wr,
  input  logic        dp_eof,
  input  logic        dp_crc_ok,
  output logic        buf_slot,
  output logic [10:0] buf_addr,
  output logic        buf_we,
  output logic        frame_ready,
  output logic        frame_slot,
  output logic [10:0] frame_len,
  input  logic        frame_ack,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  err_cnt
);

  localparam int unsigned LEN_W = 11;
  localparam int unsigned CNT_W = 8;

  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         full_q, full_d;
  logic [LEN_W-1:0]   len0_q, len0_d;
  logic [LEN_W-1:0]   len1_q, len1_d;
  logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               we_c;
  logic               err_inc_c;
  logic               drop_inc_c;
  logic               commit_c;
  logic               overflow_c;
  logic [LEN_W-1:0]   eff_len_c;

  // Next-state, queue and counter update logic.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    full_d     = full_q;
    len0_d     = len0_q;
    len1_d     = len1_q;
    byte_cnt_d = byte_cnt_q;
    we_c       = 1'b0;
    err_inc_c  = 1'b0;
    drop_inc_c = 1'b0;
    commit_c   = 1'b0;
    overflow_c = 1'b0;
    eff_len_c  = byte_cnt_q;

    if (dp_sof) begin
      // A start pulse always opens a new frame; an unfinished one is aborted.
      if (state_q == RECV) begin
        err_inc_c = 1'b1;
      end
      if (full_q[wr_ptr_q]) begin
        state_d    = DROP;
        drop_inc_c = 1'b1;
      end else begin
        state_d    = RECV;
        byte_cnt_d = '0;
      end
    end else begin
      case (state_q)
        RECV: begin
          if (dp_wr) begin
            if (byte_cnt_q == MAX_L) begin
              overflow_c = 1'b1;
              err_inc_c  = 1'b1;
              state_d    = DROP;
            end else begin
              we_c       = 1'b1;
              byte_cnt_d = byte_cnt_q + LEN_W'(1);
              eff_len_c  = byte_cnt_d;
            end
          end
          if (dp_eof) begin
            state_d = IDLE;
            // An overflowing frame is already counted as an error.
            if (!overflow_c) begin
              if (dp_crc_ok && (eff_len_c >= MIN_L) && (eff_len_c <= MAX_L)) begin
                commit_c = 1'b1;
              end else begin
                err_inc_c = 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (dp_eof) begin
            state_d = IDLE;
          end
        end
        default: begin
        end
      endcase
    end

    // Commit and ack never touch the same slot: a commit targets an empty slot.
    if (commit_c) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
      if (wr_ptr_q) begin
        len1_d = eff_len_c;
      end else begin
        len0_d = eff_len_c;
      end
    end

    if (frame_ack && full_q[rd_ptr_q]) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end

    drop_cnt_d = (drop_inc_c && (drop_cnt_q != CNT_SAT)) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    err_cnt_d  = (err_inc_c && (err_cnt_q != CNT_SAT)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end

  // State and queue registers.
  always_ff @(posedge RX_CLK or posedge rx_rst) begin
    if (rx_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      full_q     <= '0;
      len0_q     <= '0;
      len1_q     <= '0;
      byte_cnt_q <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      len0_q     <= len0_d;
      len1_q     <= len1_d;
      byte_cnt_q <= byte_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Buffer write port follows dp_wr in the same cycle.
  assign buf_we   = we_c;
  assign buf_addr = byte_cnt_q;
  assign buf_slot = wr_ptr_q;

  // Host-side view comes only from registered state.
  assign frame_ready = full_q[rd_ptr_q];
  assign frame_slot  = rd_ptr_q;
  assign frame_len   = rd_ptr_q ? len1_q : len0_q;
  assign drop_cnt    = drop_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule
